// File: rtl/param_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : param_reg_file
// Desc     : NREGS x WIDTH register file with a multi-hot write select, two
//            async read ports, sticky per-register wrap flags and a zero mask.
//            Define REGFILE_BYPASS_EN to forward post-op values to the reads.
// Revision : 1.0 - initial release
// ============================================================================
module param_reg_file #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 8,
    localparam int SELW  = $clog2(NREGS)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [1:0]       FunSel,
    input  logic [NREGS-1:0] RSel,
    input  logic [WIDTH-1:0] Load,
    input  logic [SELW-1:0]  O1Sel,
    input  logic [SELW-1:0]  O2Sel,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [NREGS-1:0] WrapFlag,
    output logic [NREGS-1:0] ZeroMask
);
    localparam logic [1:0]       c_OP_CLR  = 2'b00;
    localparam logic [1:0]       c_OP_LOAD = 2'b01;
    localparam logic [1:0]       c_OP_DEC  = 2'b10;
    localparam int               c_DEPTH   = 1 << SELW;
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ONES    = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_wrap;
    logic [WIDTH-1:0] w_next [NREGS];
    logic [NREGS-1:0] w_wrap_next;
    logic [WIDTH-1:0] w_rd_tbl [c_DEPTH];

    // Each selected register applies the op to its own value independently.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_next[i]      = r_regs[i];
            w_wrap_next[i] = r_wrap[i];
            if (Enable && RSel[i]) begin
                case (FunSel)
                    c_OP_CLR: begin
                        w_next[i]      = '0;
                        w_wrap_next[i] = 1'b0;
                    end
                    c_OP_LOAD: w_next[i] = Load;
                    c_OP_DEC: begin
                        w_next[i] = r_regs[i] - c_ONE;
                        if (r_regs[i] == '0)
                            w_wrap_next[i] = 1'b1;
                    end
                    default: begin
                        w_next[i] = r_regs[i] + c_ONE;
                        if (r_regs[i] == c_ONES)
                            w_wrap_next[i] = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
            r_wrap <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= w_next[i];
            r_wrap <= w_wrap_next;
        end
    end

    // Read table padded to a power of two so out-of-range indices read 0.
    for (genvar k = 0; k < c_DEPTH; k++) begin : g_rd_tbl
        if (k < NREGS) begin : g_live
`ifdef REGFILE_BYPASS_EN
            assign w_rd_tbl[k] = (Enable && RSel[k]) ? (Reset ? w_next[k] : '0)
                                                     : r_regs[k];
`else
            assign w_rd_tbl[k] = r_regs[k];
`endif
        end else begin : g_pad
            assign w_rd_tbl[k] = '0;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_zero
        assign ZeroMask[i] = (r_regs[i] == '0);
    end

    assign O1       = w_rd_tbl[O1Sel];
    assign O2       = w_rd_tbl[O2Sel];
    assign WrapFlag = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_param_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_reg_file
// Desc     : Directed-vector scoreboard bench for param_reg_file (8x8 and 6x8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_reg_file;
    localparam logic [1:0] c_CLR = 2'b00, c_LOAD = 2'b01, c_DEC = 2'b10, c_INC = 2'b11;
    localparam int F_O1 = 0, F_O2 = 1, F_WRAP = 2, F_ZERO = 3, F_B_O1 = 4, F_B_O2 = 5;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       r_en = 1'b0;
    logic [1:0] r_fs = 2'b00;
    logic [7:0] r_rsel = 8'h00;
    logic [7:0] r_load = 8'h00;
    logic [2:0] r_o1s = 3'd0, r_o2s = 3'd0;
    logic [7:0] w_o1, w_o2, w_wrap, w_zero;

    logic       rb_en = 1'b0;
    logic [1:0] rb_fs = 2'b00;
    logic [5:0] rb_rsel = 6'h00;
    logic [7:0] rb_load = 8'h00;
    logic [2:0] rb_o1s = 3'd0, rb_o2s = 3'd0;
    logic [7:0] wb_o1, wb_o2;
    logic [5:0] wb_wrap, wb_zero;

    int checks = 0;
    int errors = 0;
    int         q_f [$];
    logic [7:0] q_v [$];
    string      q_n [$];

    always #5 Clock = ~Clock;

    param_reg_file #(.WIDTH(8), .NREGS(8)) dut (
        .Clock(Clock), .Reset(Reset), .Enable(r_en), .FunSel(r_fs), .RSel(r_rsel),
        .Load(r_load), .O1Sel(r_o1s), .O2Sel(r_o2s), .O1(w_o1), .O2(w_o2),
        .WrapFlag(w_wrap), .ZeroMask(w_zero)
    );

    param_reg_file #(.WIDTH(8), .NREGS(6)) dut6 (
        .Clock(Clock), .Reset(Reset), .Enable(rb_en), .FunSel(rb_fs), .RSel(rb_rsel),
        .Load(rb_load), .O1Sel(rb_o1s), .O2Sel(rb_o2s), .O1(wb_o1), .O2(wb_o2),
        .WrapFlag(wb_wrap), .ZeroMask(wb_zero)
    );

    // Monitor: mid-cycle, pop every pending expectation and compare.
    always @(negedge Clock) begin
        int         f;
        logic [7:0] v, act;
        string      n;
        while (q_f.size() > 0) begin
            f = q_f.pop_front();
            v = q_v.pop_front();
            n = q_n.pop_front();
            case (f)
                F_O1:    act = w_o1;
                F_O2:    act = w_o2;
                F_WRAP:  act = w_wrap;
                F_ZERO:  act = w_zero;
                F_B_O1:  act = wb_o1;
                default: act = wb_o2;
            endcase
            checks++;
            if (act !== v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, v);
            end
        end
    end

    function automatic void exp(input int f, input logic [7:0] v, input string n);
        q_f.push_back(f);
        q_v.push_back(v);
        q_n.push_back(n);
    endfunction

    task automatic settle();
        @(negedge Clock);
        #1;
    endtask

    task automatic drive(input logic en, input logic [1:0] fs, input logic [7:0] rsel,
                         input logic [7:0] load);
        @(posedge Clock);
        #1;
        r_en = en; r_fs = fs; r_rsel = rsel; r_load = load;
    endtask

    // One op edge followed by an idle cycle, so checks never see a pending write.
    task automatic op(input logic [1:0] fs, input logic [7:0] rsel, input logic [7:0] load);
        drive(1'b1, fs, rsel, load);
        drive(1'b0, fs, rsel, load);
    endtask

    task automatic expect_a(input logic [7:0] o1, input logic [7:0] o2,
                            input logic [7:0] wr, input logic [7:0] z, input string tag);
        exp(F_O1, o1, {tag, "_O1"});
        exp(F_O2, o2, {tag, "_O2"});
        exp(F_WRAP, wr, {tag, "_WrapFlag"});
        exp(F_ZERO, z, {tag, "_ZeroMask"});
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset dominates a full-width load of FF.
        drive(1'b1, c_LOAD, 8'hFF, 8'hFF);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        r_en  = 1'b0;
        expect_a(8'h00, 8'h00, 8'h00, 8'hFF, "reset");

        // Multi-hot load, both ports.
        r_o1s = 3'd2; r_o2s = 3'd4;
        op(c_LOAD, 8'b0001_0100, 8'h95);
        expect_a(8'h95, 8'h95, 8'h00, 8'hEB, "load_multi");

        // Increment to wrap, sticky through load, cleared by clear.
        r_o1s = 3'd3;
        op(c_LOAD, 8'h08, 8'hFE);
        expect_a(8'hFE, 8'h95, 8'h00, 8'hE3, "r3_load_fe");
        op(c_INC, 8'h08, 8'h00);
        expect_a(8'hFF, 8'h95, 8'h00, 8'hE3, "r3_inc_ff");
        op(c_INC, 8'h08, 8'h00);
        expect_a(8'h00, 8'h95, 8'h08, 8'hEB, "r3_inc_wrap");
        op(c_LOAD, 8'h08, 8'h10);
        expect_a(8'h10, 8'h95, 8'h08, 8'hE3, "r3_load_sticky");
        op(c_CLR, 8'h08, 8'h77);
        expect_a(8'h00, 8'h95, 8'h00, 8'hEB, "r3_clear");

        // Decrement below zero.
        r_o1s = 3'd0;
        op(c_DEC, 8'h01, 8'h00);
        expect_a(8'hFF, 8'h95, 8'h01, 8'hEA, "r0_dec_wrap");

        // Enable low holds everything.
        drive(1'b0, c_INC, 8'hFF, 8'h77);
        for (int c = 0; c < 5; c++) begin
            @(posedge Clock);
            #1;
            expect_a(8'hFF, 8'h95, 8'h01, 8'hEA, "hold");
        end

        // Multi-hot increment: R0 wraps again, R4 counts up.
        op(c_INC, 8'b0001_0001, 8'h00);
        expect_a(8'h00, 8'h96, 8'h01, 8'hEB, "multi_inc");
        op(c_DEC, 8'b0000_0101, 8'h00);
        r_o2s = 3'd2;
        expect_a(8'hFF, 8'h94, 8'h01, 8'hEA, "multi_dec");

        // Six-entry instance: out-of-range reads and bypass timing.
        rb_o1s = 3'd6; rb_o2s = 3'd7;
        exp(F_B_O1, 8'h00, "n6_oob_O1");
        exp(F_B_O2, 8'h00, "n6_oob_O2");
        settle();
        @(posedge Clock);
        #1;
        rb_en = 1'b1; rb_fs = c_LOAD; rb_rsel = 6'b00_0010; rb_load = 8'h3C; rb_o1s = 3'd1;
`ifdef REGFILE_BYPASS_EN
        exp(F_B_O1, 8'h3C, "n6_pre_edge_O1");
`else
        exp(F_B_O1, 8'h00, "n6_pre_edge_O1");
`endif
        exp(F_B_O2, 8'h00, "n6_pre_edge_O2");
        settle();
        @(posedge Clock);
        #1;
        rb_en = 1'b0;
        exp(F_B_O1, 8'h3C, "n6_post_edge_O1");
        exp(F_B_O2, 8'h00, "n6_post_edge_O2");
        settle();

        settle();
        if (q_f.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d expected 0", q_f.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
